// File: rtl/aes_subshift_stage.sv
// aes_subshift_stage: AES round front half, SubBytes followed by ShiftRows on a
// 128-bit column-major state. SBOX_LANES S-boxes are reused over 16/SBOX_LANES
// cycles. One state is in flight at a time. Valid/ready handshake on both sides.
//
// Optional feature: define AES_SUBSHIFT_INV_EN to add dec_i (sampled on accept).
// With dec_i=1 the stage applies InvSubBytes then InvShiftRows.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid_i   in_state_i valid
//   in_ready_o   stage accepts in_state_i this cycle
//   in_state_i   128-bit AES state; column c = [127-32c -: 32], row r = [31-8r -: 8]
//   dec_i        (AES_SUBSHIFT_INV_EN only) 1 = inverse transform
//   out_valid_o  out_state_o valid
//   out_ready_i  downstream accepts out_state_o
//   out_state_o  ShiftRows(SubBytes(in_state_i)) or its inverse
module aes_subshift_stage #(
  parameter int unsigned SBOX_LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_state_i,
`ifdef AES_SUBSHIFT_INV_EN
  input  logic         dec_i,
`endif
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_state_o
);

  localparam int unsigned NumGroups = 16 / SBOX_LANES;
  localparam int unsigned CntW      = (NumGroups > 1) ? $clog2(NumGroups) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumGroups - 1);

  // Entry for byte value x sits at bits [2047-8x -: 8].
  localparam logic [2047:0] SboxFwd = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};  // 8*(255-b)
    return SboxFwd[idx +: 8];
  endfunction

`ifdef AES_SUBSHIFT_INV_EN
  localparam logic [2047:0] SboxInv = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SboxInv[idx +: 8];
  endfunction
`endif

  // Forward: out col c row r <- col (c+r)%4 row r. Inverse: col (c-r)%4 row r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[127-32*c-8*w -: 8] = inv ? s[127-32*((c+4-w)%4)-8*w -: 8]
                                   : s[127-32*((c+w)%4)-8*w -: 8];
      end
    end
    return r;
  endfunction

  typedef enum logic [1:0] {StIdle, StSub, StDone} state_e;

  state_e          st_q;
  logic [CntW-1:0] cnt_q;
  logic [127:0]    state_q;
  logic            out_valid_q;
  logic [127:0]    state_sub;
  logic            dec_sel;

`ifdef AES_SUBSHIFT_INV_EN
  logic dec_q;
  assign dec_sel = dec_q;
`else
  assign dec_sel = 1'b0;
`endif

  // Substitute the current group of SBOX_LANES bytes; byte 0 is bits [127:120].
  always_comb begin
    state_sub = state_q;
    for (int unsigned l = 0; l < SBOX_LANES; l++) begin
      int unsigned k;
      logic [3:0]  kb;
      logic [6:0]  pos;
      k   = int'(cnt_q) * SBOX_LANES + l;
      kb  = k[3:0];
      pos = {~kb, 3'b000};  // 8*(15-k)
`ifdef AES_SUBSHIFT_INV_EN
      state_sub[pos +: 8] = dec_sel ? sbox_inv(state_q[pos +: 8]) : sbox_fwd(state_q[pos +: 8]);
`else
      state_sub[pos +: 8] = sbox_fwd(state_q[pos +: 8]);
`endif
    end
  end

  // Held low while in reset, even though the FSM already sits in StIdle.
  assign in_ready_o  = rst_n & ((st_q == StIdle) | ((st_q == StDone) & out_ready_i));
  assign out_valid_o = out_valid_q;
  assign out_state_o = shift_rows(state_q, dec_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= StIdle;
      cnt_q       <= '0;
      state_q     <= '0;
      out_valid_q <= 1'b0;
`ifdef AES_SUBSHIFT_INV_EN
      dec_q       <= 1'b0;
`endif
    end else begin
      unique case (st_q)
        StIdle: begin
          if (in_valid_i) begin
            st_q    <= StSub;
            cnt_q   <= '0;
            state_q <= in_state_i;
`ifdef AES_SUBSHIFT_INV_EN
            dec_q   <= dec_i;
`endif
          end
        end
        StSub: begin
          state_q <= state_sub;
          if (cnt_q == LastCnt) begin
            st_q        <= StDone;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            if (in_valid_i) begin
              st_q    <= StSub;
              cnt_q   <= '0;
              state_q <= in_state_i;
`ifdef AES_SUBSHIFT_INV_EN
              dec_q   <= dec_i;
`endif
            end else begin
              st_q <= StIdle;
            end
          end
        end
        default: st_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_subshift_stage.sv
// Bench for aes_subshift_stage: three instances (4, 8, 16 lanes) against a
// reference model that derives the S-box from GF(2^8) arithmetic.
module tb_aes_subshift_stage;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   in_valid;
  logic [2:0]   in_ready;
  logic [2:0]   out_valid;
  logic [127:0] in_state;
  logic         out_ready;
  logic         dec;
  logic [127:0] out_state [3];

  int total = 0;
  int bad = 0;

  logic [7:0] fwd_tbl [256];
  logic [7:0] inv_tbl [256];

`ifdef AES_SUBSHIFT_INV_EN
  localparam bit HasInv = 1'b1;
`else
  localparam bit HasInv = 1'b0;
`endif

  localparam logic [127:0] VecIn  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] VecOut = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  always #5 clk = ~clk;

  aes_subshift_stage #(.SBOX_LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .in_state_i(in_state),
`ifdef AES_SUBSHIFT_INV_EN
    .dec_i(dec),
`endif
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready), .out_state_o(out_state[0])
  );

  aes_subshift_stage #(.SBOX_LANES(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .in_state_i(in_state),
`ifdef AES_SUBSHIFT_INV_EN
    .dec_i(dec),
`endif
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready), .out_state_o(out_state[1])
  );

  aes_subshift_stage #(.SBOX_LANES(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .in_state_i(in_state),
`ifdef AES_SUBSHIFT_INV_EN
    .dec_i(dec),
`endif
    .out_valid_o(out_valid[2]), .out_ready_i(out_ready), .out_state_o(out_state[2])
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_model();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      logic [7:0] av;
      av  = 8'(a);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gf_mul(av, 8'(y)) == 8'h01) inv = 8'(y);
      fwd_tbl[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    for (int a = 0; a < 256; a++) inv_tbl[fwd_tbl[a]] = 8'(a);
  endtask

  function automatic logic [127:0] ref_round(input logic [127:0] s, input logic d);
    logic [7:0]   b [4][4];
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) begin
        logic [7:0] v;
        v = s[127-32*c-8*w -: 8];
        b[c][w] = d ? inv_tbl[v] : fwd_tbl[v];
      end
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-32*c-8*w -: 8] = d ? b[(c+4-w)%4][w] : b[(c+w)%4][w];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int exp_lat(input int which);
    return (which == 0) ? 4 : (which == 1) ? 2 : 1;
  endfunction

  // One transaction on instance 'which'; called at a negedge, returns at a negedge
  // after the result has been consumed (out_ready held high).
  task automatic run_txn(input int which, input logic [127:0] din, input logic d,
                         output logic [127:0] dout, output int lat);
    int guard;
    in_state = din;
    dec = d;
    in_valid[which] = 1'b1;
    guard = 0;
    while (!in_ready[which] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    in_valid[which] = 1'b0;
    in_state = rand128();  // must be ignored once accepted
    lat = 0;
    while (!out_valid[which] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    dout = out_state[which];
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (in_ready[0] !== 1'b0) begin
      bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready[0]);
    end
    total++;
    if (out_valid[0] !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid[0]);
    end
    total++;
    if (out_state[0] !== 128'h0) begin
      bad++; $display("FAIL reset_out_state got=%h want=0", out_state[0]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready[0] !== 1'b1) begin
      bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready[0]);
    end
  endtask

  task automatic test_fips();
    logic [127:0] o;
    int lat;
    run_txn(0, VecIn, 1'b0, o, lat);
    total++;
    if (o !== VecOut) begin bad++; $display("FAIL fips_out got=%h want=%h", o, VecOut); end
    total++;
    if (lat !== 4) begin bad++; $display("FAIL fips_latency got=%0d want=4", lat); end
  endtask

  task automatic test_constants();
    logic [127:0] o;
    int lat;
    run_txn(0, {16{8'h00}}, 1'b0, o, lat);
    total++;
    if (o !== {16{8'h63}}) begin bad++; $display("FAIL zero_in got=%h want=%h", o, {16{8'h63}}); end
    run_txn(0, {16{8'hff}}, 1'b0, o, lat);
    total++;
    if (o !== {16{8'h16}}) begin bad++; $display("FAIL ff_in got=%h want=%h", o, {16{8'h16}}); end
  endtask

  task automatic test_lanes();
    logic [127:0] o;
    int lat;
    for (int w = 1; w < 3; w++) begin
      run_txn(w, VecIn, 1'b0, o, lat);
      total++;
      if (o !== VecOut) begin
        bad++; $display("FAIL lanes_out inst=%0d got=%h want=%h", w, o, VecOut);
      end
      total++;
      if (lat !== exp_lat(w)) begin
        bad++; $display("FAIL lanes_latency inst=%0d got=%0d want=%0d", w, lat, exp_lat(w));
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] din;
    logic [127:0] o;
    logic         d;
    int           lat;
    int           w;
    for (int n = 0; n < 24; n++) begin
      din = rand128();
      w = int'($urandom_range(0, 2));
      d = HasInv ? 1'($urandom_range(0, 1)) : 1'b0;
      run_txn(w, din, d, o, lat);
      total++;
      if (o !== ref_round(din, d)) begin
        bad++; $display("FAIL random_out n=%0d inst=%0d dec=%0b got=%h want=%h",
                        n, w, d, o, ref_round(din, d));
      end
      total++;
      if (lat !== exp_lat(w)) begin
        bad++; $display("FAIL random_latency n=%0d got=%0d want=%0d", n, lat, exp_lat(w));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] nxt;
    int lat;
    dec = 1'b0;
    in_state = VecIn;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    out_ready = 1'b0;
    nxt = rand128();
    in_state = nxt;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (out_valid[0] !== 1'b1) begin
        bad++; $display("FAIL stall_out_valid cyc=%0d got=%b want=1", i, out_valid[0]);
      end
      total++;
      if (out_state[0] !== VecOut) begin
        bad++; $display("FAIL stall_out_state cyc=%0d got=%h want=%h", i, out_state[0], VecOut);
      end
      total++;
      if (in_ready[0] !== 1'b0) begin
        bad++; $display("FAIL stall_in_ready cyc=%0d got=%b want=0", i, in_ready[0]);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready[0] !== 1'b1) begin
      bad++; $display("FAIL release_in_ready got=%b want=1", in_ready[0]);
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    in_state = rand128();
    lat = 0;
    while (!out_valid[0] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== 4) begin bad++; $display("FAIL stall_next_latency got=%0d want=4", lat); end
    total++;
    if (out_state[0] !== ref_round(nxt, 1'b0)) begin
      bad++; $display("FAIL stall_next_out got=%h want=%h", out_state[0], ref_round(nxt, 1'b0));
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [127:0] q[$];
    logic [127:0] exp;
    int  sent = 0;
    int  got = 0;
    int  cyc = 0;
    int  last = -1;
    bit  took = 1'b0;
    dec = 1'b0;
    out_ready = 1'b1;
    in_state = rand128();
    in_valid[0] = 1'b1;
    while (got < 6 && cyc < 200) begin
      if (took) begin
        if (sent < 6) in_state = rand128();
        else in_valid[0] = 1'b0;
        took = 1'b0;
      end
      if (out_valid[0]) begin
        exp = (q.size() > 0) ? ref_round(q[0], 1'b0) : 128'h0;
        if (q.size() > 0) void'(q.pop_front());
        total++;
        if (out_state[0] !== exp) begin
          bad++; $display("FAIL b2b_out idx=%0d got=%h want=%h", got, out_state[0], exp);
        end
        if (last >= 0) begin
          total++;
          if (cyc - last !== 5) begin
            bad++; $display("FAIL b2b_interval idx=%0d got=%0d want=5", got, cyc - last);
          end
        end
        last = cyc;
        got++;
      end
      if (in_valid[0] && in_ready[0]) begin
        q.push_back(in_state);
        sent++;
        took = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid[0] = 1'b0;
    total++;
    if (got !== 6) begin bad++; $display("FAIL b2b_count got=%0d want=6", got); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [127:0] o;
    int lat;
    dec = 1'b0;
    in_state = VecIn;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid[0] !== 1'b0) begin
      bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid[0]);
    end
    total++;
    if (out_state[0] !== 128'h0) begin
      bad++; $display("FAIL midrst_out_state got=%h want=0", out_state[0]);
    end
    total++;
    if (in_ready[0] !== 1'b0) begin
      bad++; $display("FAIL midrst_in_ready got=%b want=0", in_ready[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(0, VecIn, 1'b0, o, lat);
    total++;
    if (o !== VecOut) begin bad++; $display("FAIL midrst_next_out got=%h want=%h", o, VecOut); end
    total++;
    if (lat !== 4) begin bad++; $display("FAIL midrst_next_latency got=%0d want=4", lat); end
  endtask

`ifdef AES_SUBSHIFT_INV_EN
  task automatic test_inverse();
    logic [127:0] o;
    int lat;
    run_txn(0, VecOut, 1'b1, o, lat);
    total++;
    if (o !== VecIn) begin bad++; $display("FAIL inv_out got=%h want=%h", o, VecIn); end
    total++;
    if (lat !== 4) begin bad++; $display("FAIL inv_latency got=%0d want=4", lat); end
    run_txn(0, VecIn, 1'b0, o, lat);
    total++;
    if (o !== VecOut) begin bad++; $display("FAIL inv_enc_out got=%h want=%h", o, VecOut); end
  endtask
`endif

  initial begin
    in_valid  = 3'b000;
    in_state  = 128'h0;
    out_ready = 1'b1;
    dec       = 1'b0;
    build_model();
    test_reset();
    test_fips();
    test_constants();
    test_lanes();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef AES_SUBSHIFT_INV_EN
    test_inverse();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
